alu_accumulator: RTL and testbench

//   Accumulator-based ALU stage directly downstream of the 8x8 register set.

---
 rtl/alu_accumulator_if.sv | 25 ++
 rtl/alu_accumulator.sv | 201 ++++++++++++++++++++
 tb/tb_alu_accumulator.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_accumulator_if.sv
// alu_accumulator_if: operand/control bundle between the register set side and
// the accumulator ALU, plus the result/status signals coming back.
interface alu_accumulator_if #(
    parameter int WIDTH = 8
);
    logic             op_start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand;
    logic             drive_bus;
    logic [WIDTH-1:0] acc_out;
    logic [WIDTH-1:0] acc_hi;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    modport master (
        output op_start, opcode, operand, drive_bus,
        input  acc_out, acc_hi, flags, busy, done
    );

    modport slave (
        input  op_start, opcode, operand, drive_bus,
        output acc_out, acc_hi, flags, busy, done
    );
endinterface

// File: rtl/alu_accumulator.sv
// alu_accumulator: accumulator ALU stage fed by the register set operand bus.
// Single-cycle ops update acc/flags on the start edge; flags are {Z,N,C,V}.
// Optional feature macro ALU_MUL_EN: opcode 0xA becomes a WIDTH-step shift-add
// multiply whose 2*WIDTH product lands in {acc_hi, acc}. Without it, 0xA is a NOP.
module alu_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    alu_accumulator_if.slave  bus,
    inout  wire  [WIDTH-1:0]  data_bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ADC  = 4'hB;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             busy_w;

    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic             alu_c, alu_v, alu_wr;
    logic [WIDTH:0]   ext_sum;

    // Single-cycle ALU result and flags; opcodes without an effect keep acc and flags.
    always_comb begin
        alu_res = acc_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        ext_sum = '0;
        case (bus.opcode)
            OP_LOAD: alu_res = bus.operand;
            OP_ADD: begin
                ext_sum = {1'b0, acc_q} + {1'b0, bus.operand};
                alu_res = ext_sum[WIDTH-1:0];
                alu_c   = ext_sum[WIDTH];
                alu_v   = (acc_q[MSB] == bus.operand[MSB]) && (alu_res[MSB] != acc_q[MSB]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow.
                ext_sum = {1'b0, acc_q} - {1'b0, bus.operand};
                alu_res = ext_sum[WIDTH-1:0];
                alu_c   = ext_sum[WIDTH];
                alu_v   = (acc_q[MSB] != bus.operand[MSB]) && (alu_res[MSB] != acc_q[MSB]);
            end
            OP_ADC: begin
                ext_sum = {1'b0, acc_q} + {1'b0, bus.operand} + {{WIDTH{1'b0}}, flags_q[1]};
                alu_res = ext_sum[WIDTH-1:0];
                alu_c   = ext_sum[WIDTH];
                alu_v   = (acc_q[MSB] == bus.operand[MSB]) && (alu_res[MSB] != acc_q[MSB]);
            end
            OP_AND:  alu_res = acc_q & bus.operand;
            OP_OR:   alu_res = acc_q | bus.operand;
            OP_XOR:  alu_res = acc_q ^ bus.operand;
            OP_NOT:  alu_res = ~acc_q;
            OP_SHL: begin
                alu_res = {acc_q[MSB-1:0], 1'b0};
                alu_c   = acc_q[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, acc_q[MSB:1]};
                alu_c   = acc_q[0];
            end
            default: alu_wr = 1'b0;
        endcase
        alu_flags = alu_wr ? {(alu_res == '0), alu_res[MSB], alu_c, alu_v} : flags_q;
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Next state: dispatch in IDLE, one shift-add step per edge in MUL_RUN.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_hi_d  = acc_hi_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE: begin
                if (bus.op_start) begin
                    if (bus.opcode == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, acc_q};
                        mplier_d = bus.operand;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = MUL_RUN;
                    end else begin
                        acc_d   = alu_res;
                        flags_d = alu_flags;
                        done_d  = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    acc_d    = prod_step[WIDTH-1:0];
                    acc_hi_d = prod_step[2*WIDTH-1:WIDTH];
                    flags_d  = {(prod_step == '0), prod_step[2*WIDTH-1],
                                (prod_step[2*WIDTH-1:WIDTH] != '0),
                                (prod_step[2*WIDTH-1:WIDTH] != '0)};
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Multiply FSM state and working registers; reset aborts any multiply in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_hi_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_hi_q <= acc_hi_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_w     = (state_q == MUL_RUN);
    assign bus.acc_hi = acc_hi_q;
`else
    // Next state: every accepted op completes on its start edge.
    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        if (bus.op_start) begin
            acc_d   = alu_res;
            flags_d = alu_flags;
            done_d  = 1'b1;
        end
    end

    assign busy_w     = 1'b0;
    assign bus.acc_hi = '0;
`endif

    // Architectural accumulator, flags and the one-cycle done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign bus.acc_out = acc_q;
    assign bus.flags   = flags_q;
    assign bus.busy    = busy_w;
    assign bus.done    = done_q;

    // Release the shared bus whenever a multiply owns the accumulator.
    assign data_bus = (bus.drive_bus && !busy_w) ? acc_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_accumulator.sv
// tb_alu_accumulator: directed sequences plus randomized traffic against a
// behavioural model of the accumulator ALU (integer arithmetic, multiply as
// a countdown followed by a plain product).
module tb_alu_accumulator;
    localparam int WIDTH = 8;

    logic      clock = 1'b0;
    logic      reset = 1'b1;
    wire [7:0] data_bus;

    alu_accumulator_if #(.WIDTH(WIDTH)) bus_if ();

    alu_accumulator #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_if),
        .data_bus (data_bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_acc;
    logic [7:0] m_hi;
    logic [3:0] m_flags;
    logic       m_done;
    int         m_busy_left;
    int         m_prod;
    bit         check_en = 1'b0;

    // When the DUT should have released the bus, the bench pulls it to zero.
    assign data_bus = (bus_if.drive_bus && m_busy_left == 0) ? 8'bzzzzzzzz : 8'h00;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic bit ovf(input int s);
        return (s > 127) || (s < -128);
    endfunction

    task automatic model_reset();
        m_acc = 8'h00;
        m_hi = 8'h00;
        m_flags = 4'h0;
        m_done = 1'b0;
        m_busy_left = 0;
        m_prod = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        int a, b, c, r;
        bit cf, vf, wr, is_mul;
        m_done = 1'b0;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_acc = 8'(m_prod & 255);
                m_hi = 8'((m_prod >> 8) & 255);
                m_flags = {m_prod == 0, m_hi >= 8'h80, m_hi != 8'h00, m_hi != 8'h00};
                m_done = 1'b1;
            end
        end else if (bus_if.op_start) begin
            a = int'(m_acc);
            b = int'(bus_if.operand);
            c = int'(m_flags[1]);
            r = a; cf = 1'b0; vf = 1'b0; wr = 1'b1; is_mul = 1'b0;
            case (int'(bus_if.opcode))
                1: r = b;
                2: begin r = a + b; cf = (r > 255); vf = ovf(sgn(a) + sgn(b)); end
                3: begin r = a - b; cf = (a < b); vf = ovf(sgn(a) - sgn(b)); end
                4: r = a & b;
                5: r = a | b;
                6: r = a ^ b;
                7: r = ~a;
                8: begin r = a << 1; cf = (a >= 128); end
                9: begin r = a >> 1; cf = (a % 2 == 1); end
                10: begin
`ifdef ALU_MUL_EN
                    is_mul = 1'b1;
                    m_prod = a * b;
                    m_busy_left = WIDTH;
`endif
                    wr = 1'b0;
                end
                11: begin r = a + b + c; cf = (r > 255); vf = ovf(sgn(a) + sgn(b) + c); end
                default: wr = 1'b0;
            endcase
            if (!is_mul) begin
                m_done = 1'b1;
                if (wr) begin
                    r = r & 255;
                    m_acc = 8'(r);
                    m_flags = {r == 0, r >= 128, cf, vf};
                end
            end
        end
    endtask

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge clock) begin
        if (check_en) begin
            chk("acc_out", 16'(bus_if.acc_out), 16'(m_acc));
            chk("acc_hi", 16'(bus_if.acc_hi), 16'(m_hi));
            chk("flags", 16'(bus_if.flags), 16'(m_flags));
            chk("busy", 16'(bus_if.busy), 16'(m_busy_left != 0));
            chk("done", 16'(bus_if.done), 16'(m_done));
            chk("data_bus", 16'(data_bus),
                16'((bus_if.drive_bus && m_busy_left == 0) ? m_acc : 8'h00));
        end
    end

    task automatic cycle(input bit s, input logic [3:0] op, input logic [7:0] v, input bit drv);
        bus_if.op_start = s;
        bus_if.opcode = op;
        bus_if.operand = v;
        bus_if.drive_bus = drv;
        @(posedge clock);
        model_step();
        #1;
    endtask

    initial begin
        logic [7:0] edge_vals [5];
        bit         s, drv;
        logic [3:0] op;
        logic [7:0] v;
        edge_vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

        bus_if.op_start = 1'b0;
        bus_if.opcode = 4'h0;
        bus_if.operand = 8'h00;
        bus_if.drive_bus = 1'b0;
        model_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_acc", 16'(bus_if.acc_out), 16'h0000);
        chk("rst_flags", 16'(bus_if.flags), 16'h0000);
        chk("rst_busy", 16'(bus_if.busy), 16'h0000);
        chk("rst_done", 16'(bus_if.done), 16'h0000);
        check_en = 1'b1;
        @(posedge clock);
        #1 reset = 1'b1;

        // LOAD 7F; ADD 01 -> signed overflow into 0x80
        cycle(1'b1, 4'h1, 8'h7F, 1'b0);
        cycle(1'b1, 4'h2, 8'h01, 1'b1);
        chk("add_acc", 16'(bus_if.acc_out), 16'h0080);
        chk("add_flags", 16'(bus_if.flags), 16'b0101);
        chk("add_done", 16'(bus_if.done), 16'h0001);
        chk("add_bus", 16'(data_bus), 16'h0080);

        // LOAD 00; SUB 01 -> borrow; ADC 00 consumes the carry
        cycle(1'b1, 4'h1, 8'h00, 1'b0);
        cycle(1'b1, 4'h3, 8'h01, 1'b0);
        chk("sub_acc", 16'(bus_if.acc_out), 16'h00FF);
        chk("sub_flags", 16'(bus_if.flags), 16'b0110);
        cycle(1'b1, 4'hB, 8'h00, 1'b0);
        chk("adc_acc", 16'(bus_if.acc_out), 16'h0000);
        chk("adc_flags", 16'(bus_if.flags), 16'b1010);

        // Shifts and NOT
        cycle(1'b1, 4'h1, 8'h81, 1'b0);
        cycle(1'b1, 4'h8, 8'h00, 1'b0);
        chk("shl_acc", 16'(bus_if.acc_out), 16'h0002);
        chk("shl_flags", 16'(bus_if.flags), 16'b0010);
        cycle(1'b1, 4'h9, 8'h00, 1'b0);
        chk("shr_acc", 16'(bus_if.acc_out), 16'h0001);
        chk("shr_flags", 16'(bus_if.flags), 16'b0000);
        cycle(1'b1, 4'h7, 8'h00, 1'b0);
        chk("not_acc", 16'(bus_if.acc_out), 16'h00FE);
        chk("not_flags", 16'(bus_if.flags), 16'b0100);

        // NOP pulses done, keeps state
        cycle(1'b1, 4'h0, 8'h55, 1'b0);
        chk("nop_acc", 16'(bus_if.acc_out), 16'h00FE);
        chk("nop_flags", 16'(bus_if.flags), 16'b0100);
        chk("nop_done", 16'(bus_if.done), 16'h0001);

        // LOAD FF; MUL FF with the bus requested throughout
        cycle(1'b1, 4'h1, 8'hFF, 1'b1);
        cycle(1'b1, 4'hA, 8'hFF, 1'b1);
`ifdef ALU_MUL_EN
        chk("mul_busy", 16'(bus_if.busy), 16'h0001);
        chk("mul_bus_z", 16'(data_bus), 16'h0000);
        for (int i = 0; i < 7; i++) begin
            cycle(i % 2 == 0, 4'h2, 8'h33, 1'b1);
            chk("mul_busy_run", 16'(bus_if.busy), 16'h0001);
            chk("mul_no_done", 16'(bus_if.done), 16'h0000);
        end
        cycle(1'b0, 4'h0, 8'h00, 1'b1);
        chk("mul_acc", 16'(bus_if.acc_out), 16'h0001);
        chk("mul_hi", 16'(bus_if.acc_hi), 16'h00FE);
        chk("mul_flags", 16'(bus_if.flags), 16'b0111);
        chk("mul_done", 16'(bus_if.done), 16'h0001);
        chk("mul_busy_end", 16'(bus_if.busy), 16'h0000);
        chk("mul_bus_after", 16'(data_bus), 16'h0001);
`else
        chk("opa_acc", 16'(bus_if.acc_out), 16'h00FF);
        chk("opa_done", 16'(bus_if.done), 16'h0001);
        chk("opa_busy", 16'(bus_if.busy), 16'h0000);
        chk("opa_hi", 16'(bus_if.acc_hi), 16'h0000);
`endif

        // Reset in the middle of a multiply
        cycle(1'b1, 4'h1, 8'h5A, 1'b0);
        cycle(1'b1, 4'hA, 8'h03, 1'b0);
        cycle(1'b0, 4'h0, 8'h00, 1'b0);
        cycle(1'b0, 4'h0, 8'h00, 1'b0);
        cycle(1'b0, 4'h0, 8'h00, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        #1;
        chk("abort_acc", 16'(bus_if.acc_out), 16'h0000);
        chk("abort_hi", 16'(bus_if.acc_hi), 16'h0000);
        chk("abort_busy", 16'(bus_if.busy), 16'h0000);
        chk("abort_flags", 16'(bus_if.flags), 16'h0000);
        @(posedge clock);
        model_step();
        @(posedge clock);
        model_step();
        #1 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 4'h0, 8'h00, 1'b1);
        end

        // Randomized traffic with biased edge operands
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 9) < 7);
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) v = edge_vals[$urandom_range(0, 4)];
            else v = 8'($urandom);
            drv = 1'($urandom_range(0, 1));
            cycle(s, op, v, drv);
        end

        @(negedge clock);
        #1;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
